// File: rtl/pll_lock_ctrl.sv
// rtl/pll_lock_ctrl.sv - PLL power-up, open-loop settle, acquire and lock supervision FSM
module pll_lock_ctrl #(
   parameter int unsigned SETTLE_CYC = 2048,
   parameter logic [31:0] TOL        = 32'h64,
   parameter int unsigned LOCK_CNT   = 8,
   parameter int unsigned UNLOCK_CNT = 2,
   parameter int unsigned ACQ_TO     = 1000000,
   parameter int unsigned LINK_TO    = 8192,
   parameter int unsigned MAX_RETRY  = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        swipt_alive,
   input  logic        link,
   input  logic [31:0] f_in,
   output logic        pll_nrst,
   output logic        freq_rdy,
   output logic        locked,
   output logic        lock_lost,
   output logic        fail,
   output logic [2:0]  state
);
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RST_PLL = 3'd1,
      S_OPEN    = 3'd2,
      S_ACQ     = 3'd3,
      S_LOCKED  = 3'd4,
      S_FAIL    = 3'd5
   } state_t;

   state_t      st;
   logic        link_s1, link_s2, link_s3, edge_p;
   logic        prev_valid, in_tol, link_exp;
   logic [31:0] f_prev, diff;
   logic [31:0] tmr, link_tmr, retry_cnt, match_cnt, miss_cnt, miss_nxt;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // subtract the smaller from the larger so a downward step never wraps
   assign diff     = (f_in >= f_prev) ? (f_in - f_prev) : (f_prev - f_in);
   assign in_tol   = (diff <= TOL);
   assign link_exp = (link_tmr == LINK_TO - 1);
   assign state    = st;

   always_comb begin
      miss_nxt = miss_cnt;
      if (edge_p)
         miss_nxt = in_tol ? 32'd0 : sat_inc(miss_cnt);
      else if (link_exp)
         miss_nxt = sat_inc(miss_cnt);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st         <= S_IDLE;
         pll_nrst   <= 1'b0;
         freq_rdy   <= 1'b1;
         locked     <= 1'b0;
         lock_lost  <= 1'b0;
         fail       <= 1'b0;
         link_s1    <= 1'b0;
         link_s2    <= 1'b0;
         link_s3    <= 1'b0;
         edge_p     <= 1'b0;
         f_prev     <= 32'd0;
         tmr        <= 32'd0;
         link_tmr   <= 32'd0;
         retry_cnt  <= 32'd0;
         match_cnt  <= 32'd0;
         miss_cnt   <= 32'd0;
         prev_valid <= 1'b0;
      end else begin
         link_s1   <= link;
         link_s2   <= link_s1;
         link_s3   <= link_s2;
         edge_p    <= link_s2 & ~link_s3;
         lock_lost <= 1'b0;
         if (!en || !swipt_alive) begin
            lock_lost  <= (st == S_LOCKED);
            st         <= S_IDLE;
            pll_nrst   <= 1'b0;
            freq_rdy   <= 1'b1;
            locked     <= 1'b0;
            fail       <= 1'b0;
            tmr        <= 32'd0;
            link_tmr   <= 32'd0;
            retry_cnt  <= 32'd0;
            match_cnt  <= 32'd0;
            miss_cnt   <= 32'd0;
            prev_valid <= 1'b0;
         end else begin
            case (st)
               S_IDLE: begin
                  retry_cnt  <= 32'd0;
                  match_cnt  <= 32'd0;
                  miss_cnt   <= 32'd0;
                  prev_valid <= 1'b0;
                  tmr        <= 32'd0;
                  st         <= S_RST_PLL;
               end
               S_RST_PLL: begin
                  if (tmr == 32'd3) begin
                     st       <= S_OPEN;
                     pll_nrst <= 1'b1;
                     tmr      <= 32'd0;
                  end else begin
                     tmr <= sat_inc(tmr);
                  end
               end
               S_OPEN: begin
                  if (tmr == SETTLE_CYC - 1) begin
                     st         <= S_ACQ;
                     freq_rdy   <= 1'b0;
                     tmr        <= 32'd0;
                     link_tmr   <= 32'd0;
                     match_cnt  <= 32'd0;
                     prev_valid <= 1'b0;
                  end else begin
                     tmr <= sat_inc(tmr);
                  end
               end
               S_ACQ: begin
                  tmr      <= sat_inc(tmr);
                  link_tmr <= (edge_p || link_exp) ? 32'd0 : sat_inc(link_tmr);
                  if (edge_p) begin
                     f_prev     <= f_in;
                     prev_valid <= 1'b1;
                     if (prev_valid)
                        match_cnt <= in_tol ? sat_inc(match_cnt) : 32'd0;
                  end
                  // a completing edge is checked first so it beats a coincident timeout
                  if (edge_p && prev_valid && in_tol && (match_cnt == LOCK_CNT - 1)) begin
                     st        <= S_LOCKED;
                     locked    <= 1'b1;
                     retry_cnt <= 32'd0;
                     miss_cnt  <= 32'd0;
                  end else if (tmr == ACQ_TO - 1) begin
                     retry_cnt <= sat_inc(retry_cnt);
                     pll_nrst  <= 1'b0;
                     freq_rdy  <= 1'b1;
                     tmr       <= 32'd0;
                     if (sat_inc(retry_cnt) >= MAX_RETRY) begin
                        st   <= S_FAIL;
                        fail <= 1'b1;
                     end else begin
                        st <= S_RST_PLL;
                     end
                  end
               end
               S_LOCKED: begin
                  link_tmr <= (edge_p || link_exp) ? 32'd0 : sat_inc(link_tmr);
                  miss_cnt <= miss_nxt;
                  if (edge_p)
                     f_prev <= f_in;
                  if (miss_nxt >= UNLOCK_CNT) begin
                     st         <= S_ACQ;
                     locked     <= 1'b0;
                     lock_lost  <= 1'b1;
                     tmr        <= 32'd0;
                     link_tmr   <= 32'd0;
                     match_cnt  <= 32'd0;
                     miss_cnt   <= 32'd0;
                     prev_valid <= 1'b0;
                  end
               end
               S_FAIL: begin
                  fail <= 1'b1;
               end
               default: begin
                  st <= S_IDLE;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_pll_lock_ctrl.sv
// tb/tb_pll_lock_ctrl.sv - scoreboard bench for pll_lock_ctrl, default and short-timer instances
module tb_pll_lock_ctrl;
   localparam int A_PER    = 2439;
   localparam int B_PER    = 20;
   localparam int B_SETTLE = 16;
   localparam int B_ACQ_TO = 600;
   localparam int B_LINK   = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_en, a_alive, a_link;
   logic [31:0] a_f;
   logic        a_pll_nrst, a_freq_rdy, a_locked, a_lock_lost, a_fail;
   logic [2:0]  a_state;
   logic        b_en, b_alive, b_link;
   logic [31:0] b_f;
   logic        b_pll_nrst, b_freq_rdy, b_locked, b_lock_lost, b_fail;
   logic [2:0]  b_state;

   pll_lock_ctrl dut_a (
      .clk(clk), .rst(rst), .en(a_en), .swipt_alive(a_alive), .link(a_link), .f_in(a_f),
      .pll_nrst(a_pll_nrst), .freq_rdy(a_freq_rdy), .locked(a_locked),
      .lock_lost(a_lock_lost), .fail(a_fail), .state(a_state)
   );

   pll_lock_ctrl #(.SETTLE_CYC(B_SETTLE), .ACQ_TO(B_ACQ_TO), .LINK_TO(B_LINK)) dut_b (
      .clk(clk), .rst(rst), .en(b_en), .swipt_alive(b_alive), .link(b_link), .f_in(b_f),
      .pll_nrst(b_pll_nrst), .freq_rdy(b_freq_rdy), .locked(b_locked),
      .lock_lost(b_lock_lost), .fail(b_fail), .state(b_state)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t        exp_q[$];
   int          b_steps[$];
   int          n_chk = 0;
   int          n_err = 0;
   logic        a_run = 1'b0;
   logic        b_run = 1'b0;
   int          a_ph = A_PER - 1;
   int          b_ph = B_PER - 1;
   int          n, retries;
   logic [2:0]  prev_st;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic sb_push(input string tag, input logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      exp_q.push_back(e);
   endtask

   task automatic sb_check(input logic [31:0] obs);
      exp_t e;
      if (exp_q.size() == 0) begin
         n_err++;
         $display("FAIL sb_underflow: observed %0d with no expected entry", obs);
      end else begin
         e = exp_q.pop_front();
         check(e.tag, obs, e.val);
      end
   endtask

   // one clock; links toggle from phase counters, b applies queued f_in steps at each rise
   task automatic step();
      @(posedge clk);
      #1;
      if (a_run) begin
         a_ph   = (a_ph == A_PER - 1) ? 0 : a_ph + 1;
         a_link = (a_ph < 20);
      end else begin
         a_ph   = A_PER - 1;
         a_link = 1'b0;
      end
      if (b_run) begin
         b_ph   = (b_ph == B_PER - 1) ? 0 : b_ph + 1;
         b_link = (b_ph < 5);
         if (b_ph == 0 && b_steps.size() > 0)
            b_f = b_f + 32'(b_steps.pop_front());
      end else begin
         b_ph   = B_PER - 1;
         b_link = 1'b0;
      end
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      a_en = 1'b1; a_alive = 1'b1; a_link = 1'b0; a_f = 32'd41000;
      b_en = 1'b0; b_alive = 1'b1; b_link = 1'b0; b_f = 32'd41000;
      repeat (3) step();
      sb_push("rst_state", 0);     sb_check(a_state);
      sb_push("rst_pll_nrst", 0);  sb_check(a_pll_nrst);
      sb_push("rst_freq_rdy", 1);  sb_check(a_freq_rdy);
      sb_push("rst_locked", 0);    sb_check(a_locked);
      sb_push("rst_lock_lost", 0); sb_check(a_lock_lost);
      sb_push("rst_fail", 0);      sb_check(a_fail);
      sb_push("rst_b_state", 0);   sb_check(b_state);
      rst = 1'b0;

      // lock sequence at default timing
      n = 0;
      while (a_state != 3'd1 && n < 10) begin step(); n++; end
      sb_push("a_enter_rst_pll", 1); sb_check(a_state);
      sb_push("a_pll_nrst_delay", 4);
      n = 0;
      while (!a_pll_nrst && n < 20) begin step(); n++; end
      sb_check(n);
      sb_push("a_settle_cycles", 2048);
      n = 0;
      while (a_freq_rdy && n < 3000) begin step(); n++; end
      sb_check(n);
      sb_push("a_acq_state", 3); sb_check(a_state);
      a_run = 1'b1;
      sb_push("a_lock_cycles", 1 + 8 * A_PER + 4);
      n = 0;
      while (!a_locked && n < 25000) begin step(); n++; end
      sb_check(n);
      sb_push("a_locked_state", 4); sb_check(a_state);

      // loss of lock with one saving edge between misses
      a_run = 1'b0;
      n = 0;
      repeat (10000) begin step(); n++; end
      sb_push("a_one_miss_still_locked", 4); sb_check(a_state);
      a_link = 1'b1;
      sb_push("a_unlock_cycles", 10000 + 4 + 16384);
      while (!a_lock_lost && n < 30000) begin step(); n++; end
      sb_check(n);
      sb_push("a_unlock_state", 3); sb_check(a_state);
      sb_push("a_unlock_locked", 0); sb_check(a_locked);
      step();
      sb_push("a_lock_lost_width", 0); sb_check(a_lock_lost);
      a_en = 1'b0;

      // tolerance boundary: +100 matches, +101 clears, lock after eight clean steps
      b_en = 1'b1;
      n = 0;
      while (b_state != 3'd3 && n < 100) begin step(); n++; end
      sb_push("b_acq_state", 3); sb_check(b_state);
      b_steps.push_back(0);
      for (int k = 0; k < 2; k++) begin
         for (int j = 0; j < 7; j++) b_steps.push_back(100);
         b_steps.push_back(101);
      end
      for (int j = 0; j < 8; j++) b_steps.push_back((j % 2 == 0) ? 100 : -100);
      b_run = 1'b1;
      sb_push("b_tol_no_lock", 0);
      sb_push("b_tol_lock_cycles", 1 + 24 * B_PER + 4);
      n = 0;
      while (!b_locked && n < 800) begin
         step();
         n++;
         if (n == 340) sb_check(b_locked);
      end
      sb_check(n);

      // swipt_alive drop while locked
      b_run = 1'b0;
      b_alive = 1'b0;
      step();
      sb_push("swipt_state", 0);     sb_check(b_state);
      sb_push("swipt_locked", 0);    sb_check(b_locked);
      sb_push("swipt_lock_lost", 1); sb_check(b_lock_lost);
      sb_push("swipt_pll_nrst", 0);  sb_check(b_pll_nrst);
      step();
      sb_push("swipt_pulse_width", 0); sb_check(b_lock_lost);
      b_alive = 1'b1;

      // relock then reset while locked
      n = 0;
      while (b_state != 3'd3 && n < 100) begin step(); n++; end
      b_run = 1'b1;
      sb_push("b_relock_cycles", 1 + 8 * B_PER + 4);
      n = 0;
      while (!b_locked && n < 400) begin step(); n++; end
      sb_check(n);
      rst = 1'b1;
      b_run = 1'b0;
      step();
      sb_push("rstlk_state", 0);     sb_check(b_state);
      sb_push("rstlk_lock_lost", 0); sb_check(b_lock_lost);
      sb_push("rstlk_locked", 0);    sb_check(b_locked);
      sb_push("rstlk_pll_nrst", 0);  sb_check(b_pll_nrst);
      rst = 1'b0;

      // final matching edge processed in the acquire-timeout cycle
      n = 0;
      while (b_state != 3'd3 && n < 100) begin step(); n++; end
      repeat (435) step();
      b_run = 1'b1;
      repeat (599 - 435) step();
      sb_push("sim_pre_state", 3); sb_check(b_state);
      step();
      sb_push("sim_state", 4);  sb_check(b_state);
      sb_push("sim_locked", 1); sb_check(b_locked);

      // en drop from locked, then no link edges at all
      b_run = 1'b0;
      b_en = 1'b0;
      step();
      sb_push("en_drop_state", 0);     sb_check(b_state);
      sb_push("en_drop_lock_lost", 1); sb_check(b_lock_lost);
      b_en = 1'b1;
      sb_push("fail_cycles", 1 + 3 * (4 + B_SETTLE + B_ACQ_TO));
      sb_push("fail_retries", 2);
      n = 0;
      retries = 0;
      prev_st = b_state;
      while (b_state != 3'd5 && n < 3000) begin
         step();
         n++;
         if (prev_st == 3'd3 && b_state == 3'd1) retries++;
         prev_st = b_state;
      end
      sb_check(n);
      sb_check(retries);
      sb_push("fail_flag", 1);     sb_check(b_fail);
      sb_push("fail_pll_nrst", 0); sb_check(b_pll_nrst);
      sb_push("fail_freq_rdy", 1); sb_check(b_freq_rdy);
      repeat (10) step();
      sb_push("fail_sticky", 5); sb_check(b_state);
      b_en = 1'b0;
      step();
      sb_push("fail_exit_state", 0); sb_check(b_state);
      sb_push("fail_exit_flag", 0);  sb_check(b_fail);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
